por_seq: RTL and testbench
==========================

POR_SEQ -- requirements
Module: por_seq

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): SETTLE_CYC, 8, analog settle edges after enable; FILT_CYC, 16, consecutive high samples of pwup needed to release POR; BROWN_CYC, 4, consecutive low samples of pwup needed to re-assert POR.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 Port osc_ck, input, 1, free-running RC oscillator clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port ena, input, 1, sequencer enable, synchronous to osc_ck.
REQ-006 Port pwup_filt, input, 1, asynchronous comparator output: 1 = supply above trip.
REQ-007 Port otrip, input, 3, trip-point select code.
REQ-008 Port por_unbuf, output, 1, POR request: 1 = reset asserted.
REQ-009 Port force_pdnb, output, 1, analog enable: 0 = rstring, ibias and comparator powered down.
REQ-010 Port otrip_decoded, output, 8, one-hot trip select for the rstring mux.
REQ-011 Port por_state, output, 3, current FSM state encoding.
REQ-012 Port brown_cnt, output, 4, saturating count of brownout events.

Function
REQ-013 pwup_filt SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-flop output, pwup_s.
REQ-014 States and encodings SHALL be: IDLE=0, SETTLE=1, ARMED=2, FILTER=3, RELEASED=4, BROWN=5; codes 6-7 SHALL transition to IDLE on the next edge.
REQ-015 IDLE: force_pdnb=0, por_unbuf=1; ena=1 -> SETTLE with cnt=0.
REQ-016 SETTLE: force_pdnb=1, por_unbuf=1, pwup_s ignored; cnt increments each edge; after SETTLE_CYC edges in SETTLE -> ARMED.
REQ-017 ARMED: pwup_s=1 -> FILTER with cnt=1, counting this edge as the first high sample.
REQ-018 FILTER: pwup_s=0 -> ARMED and cnt cleared; the edge producing the FILT_CYC-th consecutive high sample -> RELEASED, with por_unbuf=0 registered on that same edge.
REQ-019 RELEASED: por_unbuf=0; pwup_s=0 -> BROWN with cnt=1.
REQ-020 BROWN: por_unbuf stays 0; pwup_s=1 -> RELEASED; the edge producing the BROWN_CYC-th consecutive low sample -> ARMED with por_unbuf=1 on that edge, and brown_cnt increments, saturating at 15.
REQ-021 ena=0 in any non-IDLE state SHALL force IDLE on the next edge (force_pdnb=0, por_unbuf=1, cnt=0); this overrides all other transitions on that edge.
REQ-022 otrip_decoded SHALL be registered 1<<otrip, updated only on edges where the state is IDLE or SETTLE; otrip changes in other states SHALL be ignored.
REQ-023 por_unbuf SHALL be 1 in every state except RELEASED and BROWN.
REQ-024 All outputs SHALL be registered and glitch-free.
REQ-025 cnt SHALL be 8 bits wide; parameter values SHALL be 1..255.

Reset
REQ-026 On an edge with rst=1 the block SHALL enter IDLE, with por_unbuf=1, force_pdnb=0, otrip_decoded=8'h01, cnt=0, brown_cnt=0, synchronizer flops=0 and por_state=0.
REQ-027 rst SHALL override ena and pwup_filt, including mid-FILTER and mid-BROWN; brown_cnt is cleared only by rst.

Verification
REQ-028 Power-up: rst then ena=1, otrip=5, pwup_filt=0 -> force_pdnb=1 after edge 1; otrip_decoded=8'h20; ARMED after edge 9; por_unbuf held at 1.
REQ-029 Release: from ARMED, pwup_filt=1 continuously -> por_unbuf falls on the 18th edge after the first sampling edge (2 synchronizer edges + 16); por_state=4.
REQ-030 Filter abort: in ARMED, pwup_filt high for 10 edges, low for 3, then high -> por_unbuf remains 1 throughout; the FILTER count restarts and release occurs 18 edges after the final rise.
REQ-031 Brownout: in RELEASED, a 3-edge low glitch -> no por; a sustained low -> por_unbuf=1 on the 6th edge after the first low sample, state ARMED, brown_cnt=1; 20 brownouts -> brown_cnt=15.
REQ-032 Disable/reset: ena=0 in RELEASED -> the next edge gives IDLE, por_unbuf=1, force_pdnb=0; rst=1 mid-FILTER -> all reset values of REQ-026 on that edge; otrip changed in RELEASED -> otrip_decoded unchanged.

Source files
------------

// File: rtl/por_seq.sv
// Power-on-reset sequencer: powers up the trip comparator, lets it settle, then filters the
// synchronized supply-good signal to release POR and re-asserts it on sustained brownouts.
module por_seq #(
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned FILT_CYC   = 16,
    parameter int unsigned BROWN_CYC  = 4
) (
    input  logic       osc_ck,
    input  logic       rst,
    input  logic       ena,
    input  logic       pwup_filt,
    input  logic [2:0] otrip,
    output logic       por_unbuf,
    output logic       force_pdnb,
    output logic [7:0] otrip_decoded,
    output logic [2:0] por_state,
    output logic [3:0] brown_cnt
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSettle   = 3'd1,
        StArmed    = 3'd2,
        StFilter   = 3'd3,
        StReleased = 3'd4,
        StBrown    = 3'd5
    } state_e;

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] FiltLast   = 8'(FILT_CYC - 1);
    localparam logic [7:0] BrownLast  = 8'(BROWN_CYC - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dec_q, dec_d;
    logic [3:0] brown_q, brown_d;
    logic [3:0] brown_inc;
    logic       por_q, por_d;
    logic       pdnb_q, pdnb_d;
    logic       sync1_q, sync2_q;
    logic       pwup_s;

    assign pwup_s    = sync2_q;
    assign brown_inc = (brown_q == 4'hF) ? brown_q : brown_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        brown_d = brown_q;

        // Trip select is frozen once the comparator is armed.
        if (state_q == StIdle || state_q == StSettle) begin
            dec_d = 8'd1 << otrip;
        end

        if (state_q != StIdle && !ena) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ena) begin
                        state_d = StSettle;
                        cnt_d   = 8'd0;
                    end
                end
                StSettle: begin
                    if (cnt_q == SettleLast) begin
                        state_d = StArmed;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StArmed: begin
                    if (pwup_s) begin
                        cnt_d   = 8'd1;
                        state_d = (FiltLast == 8'd0) ? StReleased : StFilter;
                        if (FiltLast == 8'd0) cnt_d = 8'd0;
                    end
                end
                StFilter: begin
                    if (!pwup_s) begin
                        state_d = StArmed;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == FiltLast) begin
                        state_d = StReleased;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StReleased: begin
                    if (!pwup_s) begin
                        if (BrownLast == 8'd0) begin
                            state_d = StArmed;
                            cnt_d   = 8'd0;
                            brown_d = brown_inc;
                        end else begin
                            state_d = StBrown;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StBrown: begin
                    if (pwup_s) begin
                        state_d = StReleased;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == BrownLast) begin
                        state_d = StArmed;
                        cnt_d   = 8'd0;
                        brown_d = brown_inc;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            endcase
        end

        // Outputs are registered from the next state so they change on the deciding edge.
        por_d  = !(state_d == StReleased || state_d == StBrown);
        pdnb_d = (state_d != StIdle);
    end

    always_ff @(posedge osc_ck) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            dec_q   <= 8'h01;
            brown_q <= 4'd0;
            por_q   <= 1'b1;
            pdnb_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            brown_q <= brown_d;
            por_q   <= por_d;
            pdnb_q  <= pdnb_d;
            sync1_q <= pwup_filt;
            sync2_q <= sync1_q;
        end
    end

    assign por_unbuf     = por_q;
    assign force_pdnb    = pdnb_q;
    assign otrip_decoded = dec_q;
    assign por_state     = state_q;
    assign brown_cnt     = brown_q;

endmodule

// File: tb/tb_por_seq.sv
// Directed and randomized bench for por_seq against a behavioural model of the sequencer.
module tb_por_seq;

    localparam int SETTLE = 8;
    localparam int FILT   = 16;
    localparam int BROWN  = 4;

    localparam int IDLE     = 0;
    localparam int SETTLING = 1;
    localparam int ARMED    = 2;
    localparam int FILTER   = 3;
    localparam int RELEASED = 4;
    localparam int BROWNING = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       pwup = 1'b0;
    logic [2:0] otrip = 3'd0;
    logic       por_unbuf;
    logic       force_pdnb;
    logic [7:0] otrip_decoded;
    logic [2:0] por_state;
    logic [3:0] brown_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int         m_mode = IDLE;
    int         m_run  = 0;
    int         m_brown = 0;
    logic [7:0] m_dec = 8'h01;
    logic [1:0] m_pipe = 2'b00;

    por_seq #(
        .SETTLE_CYC(SETTLE),
        .FILT_CYC  (FILT),
        .BROWN_CYC (BROWN)
    ) dut (
        .osc_ck       (clk),
        .rst          (rst),
        .ena          (ena),
        .pwup_filt    (pwup),
        .otrip        (otrip),
        .por_unbuf    (por_unbuf),
        .force_pdnb   (force_pdnb),
        .otrip_decoded(otrip_decoded),
        .por_state    (por_state),
        .brown_cnt    (brown_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void brownout();
        m_mode = ARMED;
        m_run  = 0;
        if (m_brown < 15) m_brown++;
    endfunction

    // One rising edge of the model, using the inputs the DUT just sampled.
    function automatic void model_edge();
        logic seen;
        seen   = m_pipe[1];
        m_pipe = {m_pipe[0], pwup};
        if (rst) begin
            m_mode  = IDLE;
            m_run   = 0;
            m_brown = 0;
            m_dec   = 8'h01;
            m_pipe  = 2'b00;
            return;
        end
        if (m_mode == IDLE || m_mode == SETTLING) m_dec = 8'd1 << otrip;
        if (m_mode != IDLE && !ena) begin
            m_mode = IDLE;
            m_run  = 0;
            return;
        end
        case (m_mode)
            IDLE: if (ena) begin m_mode = SETTLING; m_run = 0; end
            SETTLING: begin
                m_run++;
                if (m_run == SETTLE) begin m_mode = ARMED; m_run = 0; end
            end
            ARMED, FILTER: begin
                if (!seen) begin
                    m_mode = ARMED;
                    m_run  = 0;
                end else begin
                    m_run++;
                    m_mode = FILTER;
                    if (m_run >= FILT) begin m_mode = RELEASED; m_run = 0; end
                end
            end
            RELEASED, BROWNING: begin
                if (seen) begin
                    m_mode = RELEASED;
                    m_run  = 0;
                end else begin
                    m_run++;
                    m_mode = BROWNING;
                    if (m_run >= BROWN) brownout();
                end
            end
            default: begin m_mode = IDLE; m_run = 0; end
        endcase
    endfunction

    task automatic check_model();
        logic exp_por;
        exp_por = !(m_mode == RELEASED || m_mode == BROWNING);
        chk("por_unbuf", 8'(por_unbuf), 8'(exp_por));
        chk("force_pdnb", 8'(force_pdnb), 8'(m_mode != IDLE));
        chk("otrip_decoded", otrip_decoded, m_dec);
        chk("por_state", 8'(por_state), 8'(m_mode));
        chk("brown_cnt", 8'(brown_cnt), 8'(m_brown));
    endtask

    task automatic step(input logic r, input logic e, input logic p, input logic [2:0] o);
        @(negedge clk);
        rst   = r;
        ena   = e;
        pwup  = p;
        otrip = o;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic run(input int n, input logic r, input logic e, input logic p,
                       input logic [2:0] o);
        for (int i = 0; i < n; i++) step(r, e, p, o);
    endtask

    initial begin
        // Reset
        run(2, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("rst_por", 8'(por_unbuf), 8'd1);
        chk("rst_pdnb", 8'(force_pdnb), 8'd0);
        chk("rst_dec", otrip_decoded, 8'h01);
        chk("rst_state", 8'(por_state), 8'd0);
        chk("rst_brown", 8'(brown_cnt), 8'd0);

        // Power-up: settle then arm
        step(1'b0, 1'b1, 1'b0, 3'd5);
        chk("pu_pdnb_e1", 8'(force_pdnb), 8'd1);
        chk("pu_dec_e1", otrip_decoded, 8'h20);
        chk("pu_state_e1", 8'(por_state), 8'd1);
        run(7, 1'b0, 1'b1, 1'b0, 3'd5);
        chk("pu_state_e8", 8'(por_state), 8'd1);
        step(1'b0, 1'b1, 1'b0, 3'd5);
        chk("pu_state_e9", 8'(por_state), 8'd2);
        chk("pu_por_e9", 8'(por_unbuf), 8'd1);

        // Release after 2 + 16 edges
        run(17, 1'b0, 1'b1, 1'b1, 3'd5);
        chk("rel_por_e17", 8'(por_unbuf), 8'd1);
        step(1'b0, 1'b1, 1'b1, 3'd5);
        chk("rel_por_e18", 8'(por_unbuf), 8'd0);
        chk("rel_state", 8'(por_state), 8'd4);

        // Short glitch is absorbed; sustained low re-asserts POR on the 6th edge
        run(3, 1'b0, 1'b1, 1'b0, 3'd5);
        run(4, 1'b0, 1'b1, 1'b1, 3'd5);
        chk("glitch_por", 8'(por_unbuf), 8'd0);
        chk("glitch_state", 8'(por_state), 8'd4);
        run(5, 1'b0, 1'b1, 1'b0, 3'd5);
        chk("brown_por_e5", 8'(por_unbuf), 8'd0);
        step(1'b0, 1'b1, 1'b0, 3'd5);
        chk("brown_por_e6", 8'(por_unbuf), 8'd1);
        chk("brown_state", 8'(por_state), 8'd2);
        chk("brown_cnt1", 8'(brown_cnt), 8'd1);

        // Filter abort restarts the count
        run(10, 1'b0, 1'b1, 1'b1, 3'd5);
        chk("abort_por_hi", 8'(por_unbuf), 8'd1);
        run(3, 1'b0, 1'b1, 1'b0, 3'd5);
        run(17, 1'b0, 1'b1, 1'b1, 3'd5);
        chk("abort_por_e17", 8'(por_unbuf), 8'd1);
        step(1'b0, 1'b1, 1'b1, 3'd5);
        chk("abort_por_e18", 8'(por_unbuf), 8'd0);

        // Brownout counter saturates
        run(6, 1'b0, 1'b1, 1'b0, 3'd5);
        for (int k = 0; k < 19; k++) begin
            run(18, 1'b0, 1'b1, 1'b1, 3'd5);
            run(6, 1'b0, 1'b1, 1'b0, 3'd5);
        end
        chk("brown_sat", 8'(brown_cnt), 8'd15);

        // Trip select frozen while released, then disable
        run(18, 1'b0, 1'b1, 1'b1, 3'd5);
        run(3, 1'b0, 1'b1, 1'b1, 3'd2);
        chk("otrip_frozen", otrip_decoded, 8'h20);
        step(1'b0, 1'b0, 1'b1, 3'd2);
        chk("dis_state", 8'(por_state), 8'd0);
        chk("dis_por", 8'(por_unbuf), 8'd1);
        chk("dis_pdnb", 8'(force_pdnb), 8'd0);

        // Reset mid-FILTER
        run(9, 1'b0, 1'b1, 1'b1, 3'd3);
        run(8, 1'b0, 1'b1, 1'b1, 3'd3);
        chk("mid_filter_state", 8'(por_state), 8'd3);
        step(1'b1, 1'b1, 1'b1, 3'd3);
        chk("rstf_state", 8'(por_state), 8'd0);
        chk("rstf_por", 8'(por_unbuf), 8'd1);
        chk("rstf_pdnb", 8'(force_pdnb), 8'd0);
        chk("rstf_dec", otrip_decoded, 8'h01);
        chk("rstf_brown", 8'(brown_cnt), 8'd0);

        // Randomized supply waveform with occasional disable and reset
        begin
            int   hold;
            logic lvl;
            hold = 0;
            lvl  = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if (hold == 0) begin
                    lvl  = ~lvl;
                    hold = $urandom_range(1, 24);
                end
                hold--;
                step(($urandom_range(0, 399) == 0), ($urandom_range(0, 79) != 0), lvl,
                     3'($urandom_range(0, 7)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
